// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - Access select encodings seen on req_sel / dm_sel
//   - LSU FSM state encoding
//   - Data memory byte-address width
package mem_lsu_pkg;

  // Data memory is 8 KB, so its byte address is 13 bits wide.
  localparam int DM_AW = 13;

  localparam logic [2:0] SEL_SB     = 3'b000;
  localparam logic [2:0] SEL_SH     = 3'b001;
  localparam logic [2:0] SEL_W      = 3'b010;
  localparam logic [2:0] SEL_LBU    = 3'b011;
  localparam logic [2:0] SEL_LB     = 3'b100;
  localparam logic [2:0] SEL_LHU    = 3'b101;
  localparam logic [2:0] SEL_LH     = 3'b110;
  // Unused encoding; the memory and the alignment check treat it as a word.
  localparam logic [2:0] SEL_W_ALT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align_chk.sv
// Combinational access-legality check, shared with the exception unit.
//   sel_i  : access select (mem_lsu_pkg SEL_* encoding)
//   addr_i : full 32-bit byte address
//   err_o  : 1 when the access is out of the data memory range or misaligned
module lsu_align_chk
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  sel_i,
  input  logic [31:0] addr_i,
  output logic        err_o
);

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the case statement can leave it unassigned (latch).
  always_comb begin
    err_o = |addr_i[31:DM_AW];
    case (sel_i)
      SEL_SH, SEL_LHU, SEL_LH: if (addr_i[0])      err_o = 1'b1;
      SEL_W, SEL_W_ALT:        if (|addr_i[1:0])   err_o = 1'b1;
      default: ;  // byte accesses can never be misaligned
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store initiator driving the 8 KB data memory port.
// Accepts one access at a time over req_valid/req_ready, rejects illegal
// accesses without touching memory, holds the access on the port for
// 1+WAIT_CYCLES cycles, and returns one resp_valid pulse per request.
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : pipeline request (valid/ready, we, sel, addr, wdata)
//   resp_valid/err/rdata: one-cycle completion pulse with status and load data
//   dm_wr/sel/addr/din  : data memory port (latched request fields)
//   dm_dout             : data memory read data (combinational, pre-extended)
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_sel,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  output logic             dm_wr,
  output logic [2:0]       dm_sel,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  input  logic [31:0]      dm_dout
);

  // Equality compare on a 4-bit counter: legal WAIT_CYCLES (0..15) never wrap.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  lsu_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q;
  logic [2:0]       sel_q;
  logic [DM_AW-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             req_err;
  logic             accept;
  logic             access_done;

  lsu_align_chk u_align_chk (
    .sel_i  (req_sel),
    .addr_i (req_addr),
    .err_o  (req_err)
  );

  assign accept      = (state_q == ST_IDLE) && req_valid;
  assign access_done = (state_q == ST_ACCESS) && (cnt_q == WAIT_LAST);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = req_err ? ST_ERR : ST_ACCESS;
      ST_ACCESS: if (cnt_q == WAIT_LAST) state_d = ST_RESP;
      ST_ERR:    state_d = ST_IDLE;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Wait counter runs only while the access sits on the port.
  always_comb begin
    cnt_d = 4'd0;
    if (state_q == ST_ACCESS) cnt_d = cnt_q + 4'd1;
  end

  // Load result is cleared on accept so rejected requests and stores
  // report zero, and captured at the last ACCESS cycle.
  always_comb begin
    rdata_d = rdata_q;
    if (accept)           rdata_d = 32'd0;
    else if (access_done) rdata_d = we_q ? 32'd0 : dm_dout;
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sel_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= req_we;
        sel_q   <= req_sel;
        addr_q  <= req_addr[DM_AW-1:0];
        wdata_q <= req_wdata;
      end
    end
  end

  // Outputs. The store strobe is limited to the first ACCESS cycle so a
  // long wait does not rewrite memory; ERR never reaches ACCESS.
  always_comb begin
    req_ready  = (state_q == ST_IDLE) && !rst;
    resp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
    resp_err   = (state_q == ST_ERR);
    dm_wr      = (state_q == ST_ACCESS) && (cnt_q == 4'd0) && we_q;
  end

  assign resp_rdata = rdata_q;
  assign dm_sel     = sel_q;
  assign dm_addr    = addr_q;
  assign dm_din     = wdata_q;

endmodule
